// File: rtl/hazard_scoreboard_pkg.sv
// Shared decode constants and instruction classes for the ID-stage hazard scoreboard.
package hazard_scoreboard_pkg;

  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_BEQ     = 6'h04;
  localparam logic [5:0] OP_BNE     = 6'h05;
  localparam logic [5:0] OP_LW      = 6'h23;

  localparam logic [5:0] FN_JR      = 6'h08;
  localparam logic [5:0] FN_MFHI    = 6'h10;
  localparam logic [5:0] FN_MFLO    = 6'h12;
  localparam logic [5:0] FN_MULT    = 6'h18;
  localparam logic [5:0] FN_MULTU   = 6'h19;
  localparam logic [5:0] FN_DIV     = 6'h1a;
  localparam logic [5:0] FN_DIVU    = 6'h1b;

  // EARLY consumers resolve in ID and therefore cannot use EX/MEM forwarding.
  typedef enum logic [2:0] {
    CLS_ALU,
    CLS_EARLY,
    CLS_LOAD,
    CLS_MDU,
    CLS_HILO_RD
  } instr_class_e;

  typedef enum logic [1:0] {
    CAUSE_NONE = 2'd0,
    CAUSE_RAW  = 2'd1,
    CAUSE_MDU  = 2'd2,
    CAUSE_HILO = 2'd3
  } hazard_cause_e;

  // Maps an opcode/funct pair onto the scoreboard's instruction class.
  function automatic instr_class_e decode_class(input logic [5:0] opcode,
                                                input logic [5:0] funct);
    instr_class_e cls;
    cls = CLS_ALU;
    case (opcode)
      OP_BEQ, OP_BNE: cls = CLS_EARLY;
      OP_LW:          cls = CLS_LOAD;
      OP_SPECIAL: begin
        case (funct)
          FN_JR:                              cls = CLS_EARLY;
          FN_MULT, FN_MULTU, FN_DIV, FN_DIVU: cls = CLS_MDU;
          FN_MFHI, FN_MFLO:                   cls = CLS_HILO_RD;
          default:                            cls = CLS_ALU;
        endcase
      end
      default: cls = CLS_ALU;
    endcase
    return cls;
  endfunction

endpackage

// File: rtl/hazard_scoreboard_entry.sv
// One countdown cell of the scoreboard: counts down to zero, reloads on issue
// keeping the later of the pending and new completion, and holds while frozen.
module hazard_sb_entry #(
  parameter int CNT_W = 3
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             freeze_i,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W-1:0] dec;

  assign dec   = (cnt_q == '0) ? '0 : cnt_q - CNT_W'(1);
  assign cnt_o = cnt_q;

  // Next count: hold when frozen, otherwise the larger of the decremented value and a new load.
  always_comb begin
    cnt_d = cnt_q;
    if (!freeze_i) begin
      cnt_d = dec;
      if (load_i && (load_val_i > dec)) begin
        cnt_d = load_val_i;
      end
    end
  end

  // Countdown register; reset discards any pending producer.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// ID-stage interlock: per-register countdown scoreboard (GPR 1..31 plus HILO)
// deciding stalls, bubble insertion and a saturating stall-cycle counter.
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
#(
  parameter int FWD_EN  = 1,
  parameter int MDU_LAT = 4,
  parameter int WB_DIST = 3,
  parameter int CNT_W   = 3,
  parameter int PERF_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [5:0]        id_opcode,
  input  logic [5:0]        id_funct,
  input  logic [4:0]        id_rs,
  input  logic [4:0]        id_rt,
  input  logic              id_rs_is_source,
  input  logic              id_rt_is_source,
  input  logic              id_reg_write,
  input  logic [4:0]        id_dst_reg,
  input  logic              id_flush,
  input  logic              pipe_freeze,
  output logic              pc_write,
  output logic              if_id_write_en,
  output logic              id_ex_bubble,
  output logic              hazard_detected,
  output logic [1:0]        hazard_cause,
  output logic [PERF_W-1:0] stall_cycles
);

  // Without forwarding every producer simply waits for write-back.
  localparam logic [CNT_W-1:0] LAT_ALU  = (FWD_EN != 0) ? CNT_W'(1) : CNT_W'(WB_DIST);
  localparam logic [CNT_W-1:0] LAT_LOAD = (FWD_EN != 0) ? CNT_W'(2) : CNT_W'(WB_DIST);
  localparam logic [CNT_W-1:0] LAT_MDU  = (FWD_EN != 0) ? CNT_W'(MDU_LAT + 1) : CNT_W'(WB_DIST);

  instr_class_e     id_class;
  logic             is_early;
  logic             is_load;
  logic             is_mdu;
  logic             is_hilo_rd;
  logic             strict_src;

  logic [CNT_W-1:0] gpr_cnt [32];
  logic [CNT_W-1:0] hilo_cnt;
  logic [CNT_W-1:0] rs_cnt;
  logic [CNT_W-1:0] rt_cnt;

  logic             rs_block;
  logic             rt_block;
  logic             raw_data;
  logic             hilo_busy;
  logic             raw_hilo;
  logic             mdu_busy;
  logic             in_play;
  logic             stall;
  logic             issue;
  logic             gpr_load;
  logic             hilo_load;
  logic [CNT_W-1:0] gpr_lat;
  hazard_cause_e    cause;

  logic [PERF_W-1:0] stall_cycles_q;
  logic [PERF_W-1:0] stall_cycles_d;

  assign id_class   = decode_class(id_opcode, id_funct);
  assign is_early   = (id_class == CLS_EARLY);
  assign is_load    = (id_class == CLS_LOAD);
  assign is_mdu     = (id_class == CLS_MDU);
  assign is_hilo_rd = (id_class == CLS_HILO_RD);

  // Branch/JR operands are needed in ID, so they must wait for a zero count.
  assign strict_src = is_early || (FWD_EN == 0);

  assign rs_cnt = gpr_cnt[id_rs];
  assign rt_cnt = gpr_cnt[id_rt];

  assign rs_block = id_rs_is_source && (id_rs != 5'd0) &&
                    (strict_src ? (rs_cnt != '0) : (rs_cnt > CNT_W'(1)));
  assign rt_block = id_rt_is_source && (id_rt != 5'd0) &&
                    (strict_src ? (rt_cnt != '0) : (rt_cnt > CNT_W'(1)));

  assign raw_data  = rs_block || rt_block;
  assign hilo_busy = (hilo_cnt > CNT_W'(1));
  assign raw_hilo  = is_hilo_rd && hilo_busy;
  assign mdu_busy  = is_mdu && hilo_busy;

  assign in_play = id_valid && !id_flush;
  assign stall   = in_play && (raw_data || raw_hilo || mdu_busy);

  assign issue     = in_play && !stall && !pipe_freeze && (id_reg_write || is_mdu);
  assign gpr_load  = issue && id_reg_write && (id_dst_reg != 5'd0);
  assign hilo_load = issue && is_mdu;
  assign gpr_lat   = is_load ? LAT_LOAD : LAT_ALU;

  // Stall reason, prioritised data RAW, then HILO RAW, then MDU occupancy.
  always_comb begin
    cause = CAUSE_NONE;
    if (stall) begin
      if (raw_data) begin
        cause = CAUSE_RAW;
      end else if (raw_hilo) begin
        cause = CAUSE_HILO;
      end else begin
        cause = CAUSE_MDU;
      end
    end
  end

  assign pc_write        = !stall && !pipe_freeze;
  assign if_id_write_en  = !stall && !pipe_freeze;
  assign id_ex_bubble    = stall && !pipe_freeze;
  assign hazard_detected = stall;
  assign hazard_cause    = cause;
  assign stall_cycles    = stall_cycles_q;

  // Register 0 is hard-wired, so its entry is permanently idle.
  assign gpr_cnt[0] = '0;

  genvar g;
  for (g = 1; g < 32; g++) begin : g_gpr
    hazard_sb_entry #(
      .CNT_W(CNT_W)
    ) u_entry (
      .clk_i     (clk),
      .rst_i     (rst),
      .freeze_i  (pipe_freeze),
      .load_i    (gpr_load && (id_dst_reg == 5'(g))),
      .load_val_i(gpr_lat),
      .cnt_o     (gpr_cnt[g])
    );
  end

  hazard_sb_entry #(
    .CNT_W(CNT_W)
  ) u_hilo (
    .clk_i     (clk),
    .rst_i     (rst),
    .freeze_i  (pipe_freeze),
    .load_i    (hilo_load),
    .load_val_i(LAT_MDU),
    .cnt_o     (hilo_cnt)
  );

  // Next stall count: advance on each bubble, sticking at all-ones.
  always_comb begin
    stall_cycles_d = stall_cycles_q;
    if (id_ex_bubble && (stall_cycles_q != '1)) begin
      stall_cycles_d = stall_cycles_q + PERF_W'(1);
    end
  end

  // Stall-cycle performance counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cycles_q <= '0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Testbench for hazard_scoreboard: two instances (with and without forwarding)
// share one instruction stream and are compared each cycle against a
// timestamp-based model of when each register's value becomes usable.
module tb_hazard_scoreboard;

  localparam int MDU_LAT = 4;
  localparam int WB_DIST = 3;
  localparam int CNT_W   = 3;
  localparam int PERF_W  = 32;
  localparam int HILO    = 32;

  typedef struct packed {
    logic       valid;
    logic [5:0] op;
    logic [5:0] fn;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       rsSrc;
    logic       rtSrc;
    logic       regWrite;
    logic [4:0] dst;
    logic       flush;
  } instr_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic idValid = 1'b0;
  logic [5:0] idOpcode = '0;
  logic [5:0] idFunct = '0;
  logic [4:0] idRs = '0;
  logic [4:0] idRt = '0;
  logic idRsSrc = 1'b0;
  logic idRtSrc = 1'b0;
  logic idRegWrite = 1'b0;
  logic [4:0] idDst = '0;
  logic idFlush = 1'b0;
  logic pipeFreeze = 1'b0;

  logic pcWriteA, ifIdWriteA, bubbleA, hazardA;
  logic [1:0] causeA;
  logic [PERF_W-1:0] stallCyclesA;
  logic pcWriteB, ifIdWriteB, bubbleB, hazardB;
  logic [1:0] causeB;
  logic [PERF_W-1:0] stallCyclesB;

  always #5 clk = ~clk;

  hazard_scoreboard #(
    .FWD_EN(1), .MDU_LAT(MDU_LAT), .WB_DIST(WB_DIST), .CNT_W(CNT_W), .PERF_W(PERF_W)
  ) dut (
    .clk(clk), .rst(rst), .id_valid(idValid), .id_opcode(idOpcode), .id_funct(idFunct),
    .id_rs(idRs), .id_rt(idRt), .id_rs_is_source(idRsSrc), .id_rt_is_source(idRtSrc),
    .id_reg_write(idRegWrite), .id_dst_reg(idDst), .id_flush(idFlush), .pipe_freeze(pipeFreeze),
    .pc_write(pcWriteA), .if_id_write_en(ifIdWriteA), .id_ex_bubble(bubbleA),
    .hazard_detected(hazardA), .hazard_cause(causeA), .stall_cycles(stallCyclesA)
  );

  hazard_scoreboard #(
    .FWD_EN(0), .MDU_LAT(MDU_LAT), .WB_DIST(WB_DIST), .CNT_W(CNT_W), .PERF_W(PERF_W)
  ) dutNoFwd (
    .clk(clk), .rst(rst), .id_valid(idValid), .id_opcode(idOpcode), .id_funct(idFunct),
    .id_rs(idRs), .id_rt(idRt), .id_rs_is_source(idRsSrc), .id_rt_is_source(idRtSrc),
    .id_reg_write(idRegWrite), .id_dst_reg(idDst), .id_flush(idFlush), .pipe_freeze(pipeFreeze),
    .pc_write(pcWriteB), .if_id_write_en(ifIdWriteB), .id_ex_bubble(bubbleB),
    .hazard_detected(hazardB), .hazard_cause(causeB), .stall_cycles(stallCyclesB)
  );

  int compared = 0;
  int mismatched = 0;

  // Model state per instance: absolute time at which each register's pending
  // producer is fully complete, an unfrozen-cycle clock, and a bubble tally.
  int readyAt [2][33];
  int nowT [2];
  int stallCnt [2];
  logic modelStall [2];
  logic [1:0] modelCause [2];
  bit accepted [2];

  instr_t stg;
  logic stgFreeze = 1'b0;
  logic stgRst = 1'b1;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: observed %0h expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  // 0 plain ALU, 1 branch/JR, 2 load, 3 multiply/divide, 4 MFHI/MFLO
  function automatic int classOf(input logic [5:0] op, input logic [5:0] fn);
    if (op == 6'h04 || op == 6'h05) return 1;
    if (op == 6'h23) return 2;
    if (op == 6'h00) begin
      if (fn == 6'h08) return 1;
      if (fn >= 6'h18 && fn <= 6'h1b) return 3;
      if (fn == 6'h10 || fn == 6'h12) return 4;
    end
    return 0;
  endfunction

  function automatic instr_t mk(input logic [5:0] op, input logic [5:0] fn, input logic [4:0] rs,
                                input logic [4:0] rt, input logic rsSrc, input logic rtSrc,
                                input logic rw, input logic [4:0] dst);
    instr_t i;
    i.valid = 1'b1; i.op = op; i.fn = fn; i.rs = rs; i.rt = rt;
    i.rsSrc = rsSrc; i.rtSrc = rtSrc; i.regWrite = rw; i.dst = dst; i.flush = 1'b0;
    return i;
  endfunction

  function automatic instr_t addI(input logic [4:0] rd, input logic [4:0] rs, input logic [4:0] rt);
    return mk(6'h00, 6'h20, rs, rt, 1'b1, 1'b1, 1'b1, rd);
  endfunction
  function automatic instr_t lwI(input logic [4:0] rt);
    return mk(6'h23, 6'h00, 5'd0, rt, 1'b1, 1'b0, 1'b1, rt);
  endfunction
  function automatic instr_t beqI(input logic [4:0] rs, input logic [4:0] rt);
    return mk(6'h04, 6'h00, rs, rt, 1'b1, 1'b1, 1'b0, 5'd0);
  endfunction
  function automatic instr_t multI(input logic [4:0] rs, input logic [4:0] rt);
    return mk(6'h00, 6'h18, rs, rt, 1'b1, 1'b1, 1'b0, 5'd0);
  endfunction
  function automatic instr_t mfloI(input logic [4:0] rd);
    return mk(6'h00, 6'h12, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, rd);
  endfunction

  function automatic instr_t randInstr();
    instr_t i;
    logic [4:0] a, b, d;
    a = 5'($urandom_range(0, 7));
    b = 5'($urandom_range(0, 7));
    d = 5'($urandom_range(0, 7));
    case ($urandom_range(0, 9))
      0: i = addI(d, a, b);
      1: i = lwI(d);
      2: i = beqI(a, b);
      3: i = mk(6'h05, 6'h00, a, b, 1'b1, 1'b1, 1'b0, 5'd0);
      4: i = mk(6'h00, 6'h08, a, 5'd0, 1'b1, 1'b0, 1'b0, 5'd0);
      5: i = multI(a, b);
      6: i = mk(6'h00, 6'h1b, a, b, 1'b1, 1'b1, 1'b0, 5'd0);
      7: i = mk(6'h00, 6'h10, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, d);
      8: i = mfloI(d);
      default: i = mk(6'h0d, 6'h00, a, d, 1'b1, 1'b0, 1'b1, d);
    endcase
    i.valid = ($urandom_range(0, 9) != 0);
    i.flush = ($urandom_range(0, 19) == 0);
    return i;
  endfunction

  function automatic int maxI(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  task automatic clearModel(input int m);
    for (int r = 0; r < 33; r++) readyAt[m][r] = 0;
    stallCnt[m] = 0;
  endtask

  // A consumer that forwards from EX/MEM may proceed one cycle before its
  // producer completes; branches, JR and no-forwarding consumers may not.
  task automatic evalModel(input int m);
    int cls;
    bit fwd, raw, hiloWait;
    cls = classOf(stg.op, stg.fn);
    fwd = (m == 0);
    raw = 0;
    if (stg.rsSrc && stg.rs != 0)
      raw |= (cls == 1 || !fwd) ? (nowT[m] < readyAt[m][stg.rs]) : (nowT[m] < readyAt[m][stg.rs] - 1);
    if (stg.rtSrc && stg.rt != 0)
      raw |= (cls == 1 || !fwd) ? (nowT[m] < readyAt[m][stg.rt]) : (nowT[m] < readyAt[m][stg.rt] - 1);
    hiloWait = (nowT[m] < readyAt[m][HILO] - 1);
    modelStall[m] = stg.valid && !stg.flush && (raw || ((cls == 3 || cls == 4) && hiloWait));
    if (!modelStall[m]) modelCause[m] = 2'd0;
    else if (raw) modelCause[m] = 2'd1;
    else if (cls == 4) modelCause[m] = 2'd3;
    else modelCause[m] = 2'd2;
  endtask

  task automatic updateModel(input int m);
    int cls, lat;
    bit fwd, issue;
    cls = classOf(stg.op, stg.fn);
    fwd = (m == 0);
    issue = stg.valid && !stg.flush && !modelStall[m] && (stg.regWrite || cls == 3);
    if (issue && cls == 3)
      readyAt[m][HILO] = maxI(readyAt[m][HILO], nowT[m] + 1 + (fwd ? MDU_LAT + 1 : WB_DIST));
    if (issue && stg.regWrite && stg.dst != 0) begin
      lat = fwd ? ((cls == 2) ? 2 : 1) : WB_DIST;
      readyAt[m][stg.dst] = maxI(readyAt[m][stg.dst], nowT[m] + 1 + lat);
    end
    if (modelStall[m]) stallCnt[m]++;
    nowT[m]++;
  endtask

  task automatic applyStimulus();
    @(negedge clk);
    rst = stgRst; pipeFreeze = stgFreeze;
    idValid = stg.valid; idOpcode = stg.op; idFunct = stg.fn; idRs = stg.rs; idRt = stg.rt;
    idRsSrc = stg.rsSrc; idRtSrc = stg.rtSrc; idRegWrite = stg.regWrite; idDst = stg.dst;
    idFlush = stg.flush;
  endtask

  task automatic runCycle();
    logic fz;
    applyStimulus();
    #1;
    if (stgRst) begin clearModel(0); clearModel(1); end
    evalModel(0);
    evalModel(1);
    fz = stgFreeze;
    checkOutput("ctl_fwd", {26'd0, pcWriteA, ifIdWriteA, bubbleA, hazardA, causeA},
                {26'd0, !modelStall[0] && !fz, !modelStall[0] && !fz, modelStall[0] && !fz,
                 modelStall[0], modelCause[0]});
    checkOutput("perf_fwd", stallCyclesA, stallCnt[0]);
    checkOutput("ctl_nofwd", {26'd0, pcWriteB, ifIdWriteB, bubbleB, hazardB, causeB},
                {26'd0, !modelStall[1] && !fz, !modelStall[1] && !fz, modelStall[1] && !fz,
                 modelStall[1], modelCause[1]});
    checkOutput("perf_nofwd", stallCyclesB, stallCnt[1]);
    if (!stgRst && !fz) begin
      updateModel(0);
      updateModel(1);
    end
    accepted[0] = !stgRst && !fz && !modelStall[0];
    accepted[1] = !stgRst && !fz && !modelStall[1];
  endtask

  // Present an instruction until the chosen instance accepts it.
  task automatic issueInstr(input instr_t ins, input int m);
    stg = ins; stgFreeze = 1'b0; stgRst = 1'b0;
    for (int n = 0; n < 30; n++) begin
      runCycle();
      if (accepted[m]) return;
    end
    checkOutput("accept_timeout", 32'd1, 32'd0);
  endtask

  task automatic doReset();
    stg = '0; stgFreeze = 1'b0; stgRst = 1'b1;
    runCycle();
    stgRst = 1'b0;
  endtask

  initial begin
    logic [PERF_W-1:0] s0;
    for (int m = 0; m < 2; m++) begin clearModel(m); nowT[m] = 0; accepted[m] = 1'b1; end
    stg = '0;

    doReset();
    checkOutput("reset_ctl", {26'd0, pcWriteA, ifIdWriteA, bubbleA, hazardA, causeA}, 32'h30);
    checkOutput("reset_perf", stallCyclesA, 32'd0);

    issueInstr(addI(5'd3, 5'd1, 5'd2), 0);
    s0 = stallCyclesA;
    issueInstr(addI(5'd4, 5'd3, 5'd5), 0);
    checkOutput("alu_use_bubbles", stallCyclesA - s0, 32'd0);

    issueInstr(lwI(5'd3), 0);
    s0 = stallCyclesA;
    stg = addI(5'd4, 5'd3, 5'd3); runCycle();
    checkOutput("lw_use_cause", {30'd0, causeA}, 32'd1);
    issueInstr(addI(5'd4, 5'd3, 5'd3), 0);
    checkOutput("lw_use_bubbles", stallCyclesA - s0, 32'd1);

    issueInstr(lwI(5'd3), 0);
    s0 = stallCyclesA;
    issueInstr(beqI(5'd3, 5'd0), 0);
    checkOutput("lw_branch_bubbles", stallCyclesA - s0, 32'd2);

    issueInstr(addI(5'd6, 5'd1, 5'd2), 0);
    s0 = stallCyclesA;
    issueInstr(beqI(5'd6, 5'd0), 0);
    checkOutput("alu_branch_bubbles", stallCyclesA - s0, 32'd1);

    issueInstr(multI(5'd1, 5'd2), 0);
    s0 = stallCyclesA;
    stg = mfloI(5'd6); runCycle();
    checkOutput("mflo_cause", {30'd0, causeA}, 32'd3);
    issueInstr(mfloI(5'd6), 0);
    checkOutput("mflo_bubbles", stallCyclesA - s0, 32'd4);

    issueInstr(multI(5'd1, 5'd2), 0);
    s0 = stallCyclesA;
    stg = multI(5'd3, 5'd4); runCycle();
    checkOutput("mdu_busy_cause", {30'd0, causeA}, 32'd2);
    issueInstr(multI(5'd3, 5'd4), 0);
    checkOutput("mdu_busy_bubbles", stallCyclesA - s0, 32'd4);

    issueInstr(lwI(5'd7), 0);
    s0 = stallCyclesA;
    stg = addI(5'd8, 5'd7, 5'd7); stgFreeze = 1'b1;
    for (int k = 0; k < 3; k++) runCycle();
    checkOutput("freeze_hold_perf", stallCyclesA - s0, 32'd0);
    issueInstr(addI(5'd8, 5'd7, 5'd7), 0);
    checkOutput("freeze_bubbles", stallCyclesA - s0, 32'd1);

    issueInstr(multI(5'd1, 5'd2), 0);
    issueInstr(mk(6'h00, 6'h21, 5'd1, 5'd1, 1'b1, 1'b1, 1'b1, 5'd2), 0);
    issueInstr(lwI(5'd2), 0);
    s0 = stallCyclesA;
    issueInstr(addI(5'd9, 5'd2, 5'd2), 0);
    checkOutput("waw_bubbles", stallCyclesA - s0, 32'd1);

    issueInstr(lwI(5'd3), 0);
    stg = addI(5'd4, 5'd3, 5'd3); runCycle();
    stgRst = 1'b1; runCycle();
    checkOutput("rst_pc_write", {31'd0, pcWriteA}, 32'd1);
    checkOutput("rst_perf", stallCyclesA, 32'd0);
    stgRst = 1'b0;

    issueInstr(addI(5'd3, 5'd1, 5'd2), 1);
    s0 = stallCyclesB;
    issueInstr(addI(5'd4, 5'd3, 5'd3), 1);
    checkOutput("nofwd_bubbles", stallCyclesB - s0, 32'd3);

    for (int i = 0; i < 2000; i++) begin
      if (accepted[0]) stg = randInstr();
      stgFreeze = ($urandom_range(0, 9) == 0);
      stgRst = ($urandom_range(0, 99) == 0);
      runCycle();
    end
    stgRst = 1'b0; stgFreeze = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
